// File: rtl/lc3_writeback_if.sv
// rtl/lc3_writeback_if.sv - LC3 writeback stage signal bundle
//
// Groups every non-clock/reset signal of lc3_writeback.
//   master : upstream/downstream pipeline side (drives selects, data, indices)
//   slave  : the writeback stage itself
// Signals:
//   enable_writeback     commit strobe
//   W_Control[1:0]       result select 0 alu / 1 mem / 2 pc / 3 illegal
//   aluout/memout/pcout  candidate results (16 bit)
//   dr, sr1, sr2         destination and read-port indices (3 bit)
//   vsr1, vsr2           read-port data (16 bit)
//   psr[2:0]             condition codes {N,Z,P}
//   enable_writeback_pt  write committed last cycle
//   wb_err               sticky illegal-select flag
//   commit_count[15:0]   committed write counter, wraps
interface lc3_writeback_if;
  logic        enable_writeback;
  logic [1:0]  W_Control;
  logic [15:0] aluout;
  logic [15:0] memout;
  logic [15:0] pcout;
  logic [2:0]  dr;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [15:0] vsr1;
  logic [15:0] vsr2;
  logic [2:0]  psr;
  logic        enable_writeback_pt;
  logic        wb_err;
  logic [15:0] commit_count;

  modport master (
    output enable_writeback, W_Control, aluout, memout, pcout, dr, sr1, sr2,
    input  vsr1, vsr2, psr, enable_writeback_pt, wb_err, commit_count
  );

  modport slave (
    input  enable_writeback, W_Control, aluout, memout, pcout, dr, sr1, sr2,
    output vsr1, vsr2, psr, enable_writeback_pt, wb_err, commit_count
  );
endinterface

// File: rtl/lc3_writeback.sv
// rtl/lc3_writeback.sv - LC3 writeback stage: result select, 8x16 register file, PSR update
//
// Ports:
//   clock  pipeline clock, rising edge
//   reset  asynchronous active-low reset, clears all state
//   wb     lc3_writeback_if.slave (see interface file for signal list)
// Optional feature:
//   WB_BYPASS_EN  when defined, a legal commit is forwarded to vsr1/vsr2 in the
//                 same cycle if the read index matches dr; otherwise reads see
//                 stored contents only.
module lc3_writeback (
  input  logic              clock,
  input  logic              reset,
  lc3_writeback_if.slave    wb
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] rf_q [8];
  logic [15:0] rf_d [8];
  logic [2:0]  psr_q, psr_d;
  logic        wb_err_q, wb_err_d;
  logic [15:0] commit_count_q, commit_count_d;

  logic [15:0] dr_in;
  logic        commit;

  // Result select; code 3 never commits, so its data value is irrelevant.
  always_comb begin
    dr_in = 16'h0000;
    case (wb.W_Control)
      2'd0:    dr_in = wb.aluout;
      2'd1:    dr_in = wb.memout;
      2'd2:    dr_in = wb.pcout;
      default: dr_in = 16'h0000;
    endcase
  end

  assign commit = wb.enable_writeback && (wb.W_Control != 2'd3);

  // Commit FSM plus datapath next-state.
  always_comb begin
    state_d        = ST_IDLE;
    psr_d          = psr_q;
    wb_err_d       = wb_err_q;
    commit_count_d = commit_count_q;
    for (int i = 0; i < 8; i++) rf_d[i] = rf_q[i];

    case (state_q)
      ST_IDLE:   state_d = commit ? ST_COMMIT : ST_IDLE;
      ST_COMMIT: state_d = commit ? ST_COMMIT : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (commit) begin
      rf_d[wb.dr]    = dr_in;
      commit_count_d = commit_count_q + 16'd1;
      if (dr_in[15])              psr_d = 3'b100;
      else if (dr_in == 16'h0000) psr_d = 3'b010;
      else                        psr_d = 3'b001;
    end

    if (wb.enable_writeback && (wb.W_Control == 2'd3)) begin
      wb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      psr_q          <= 3'b000;
      wb_err_q       <= 1'b0;
      commit_count_q <= 16'h0000;
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
    end else begin
      state_q        <= state_d;
      psr_q          <= psr_d;
      wb_err_q       <= wb_err_d;
      commit_count_q <= commit_count_d;
      for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
    end
  end

  // Read ports.
  always_comb begin
    wb.vsr1 = rf_q[wb.sr1];
    wb.vsr2 = rf_q[wb.sr2];
`ifdef WB_BYPASS_EN
    if (commit && (wb.sr1 == wb.dr)) wb.vsr1 = dr_in;
    if (commit && (wb.sr2 == wb.dr)) wb.vsr2 = dr_in;
`endif
  end

  assign wb.psr                 = psr_q;
  assign wb.wb_err              = wb_err_q;
  assign wb.commit_count        = commit_count_q;
  assign wb.enable_writeback_pt = (state_q == ST_COMMIT);

endmodule

// File: tb/tb_lc3_writeback.sv
// tb/tb_lc3_writeback.sv - directed self-checking bench for lc3_writeback
module tb_lc3_writeback;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  lc3_writeback_if wb_if ();

  lc3_writeback dut (
    .clock (clock),
    .reset (reset),
    .wb    (wb_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    wb_if.enable_writeback = 1'b0;
    wb_if.W_Control = 2'd0;
    wb_if.aluout = 16'h0000;
    wb_if.memout = 16'h0000;
    wb_if.pcout  = 16'h0000;
    wb_if.dr  = 3'd0;
    wb_if.sr1 = 3'd0;
    wb_if.sr2 = 3'd7;

    // Reset then idle.
    repeat (3) tick();
    chk("rst_vsr1", wb_if.vsr1, 16'h0000);
    chk("rst_vsr2", wb_if.vsr2, 16'h0000);
    chk("rst_psr", {13'd0, wb_if.psr}, 16'h0000);
    chk("rst_cnt", wb_if.commit_count, 16'h0000);
    chk("rst_pt", {15'd0, wb_if.enable_writeback_pt}, 16'h0000);
    chk("rst_err", {15'd0, wb_if.wb_err}, 16'h0000);
    reset = 1'b1;
    tick();
    chk("idle_pt", {15'd0, wb_if.enable_writeback_pt}, 16'h0000);

    // ALU commit.
    wb_if.enable_writeback = 1'b1;
    wb_if.W_Control = 2'd0;
    wb_if.aluout = 16'h8001;
    wb_if.dr  = 3'd3;
    wb_if.sr1 = 3'd3;
    tick();
    wb_if.enable_writeback = 1'b0;
    #1;
    chk("alu_vsr1", wb_if.vsr1, 16'h8001);
    chk("alu_psr", {13'd0, wb_if.psr}, 16'h0004);
    chk("alu_pt", {15'd0, wb_if.enable_writeback_pt}, 16'h0001);
    chk("alu_cnt", wb_if.commit_count, 16'h0001);
    tick();
    chk("alu_pt_drop", {15'd0, wb_if.enable_writeback_pt}, 16'h0000);
    chk("alu_hold", wb_if.vsr1, 16'h8001);

    // Memory result zero, then PC result, back to back.
    wb_if.enable_writeback = 1'b1;
    wb_if.W_Control = 2'd1;
    wb_if.memout = 16'h0000;
    wb_if.aluout = 16'h7777;
    wb_if.dr  = 3'd5;
    tick();
    wb_if.sr2 = 3'd5;
    #1;
    chk("mem_psr", {13'd0, wb_if.psr}, 16'h0002);
    chk("mem_vsr2", wb_if.vsr2, 16'h0000);
    chk("mem_cnt", wb_if.commit_count, 16'h0002);
    wb_if.W_Control = 2'd2;
    wb_if.pcout = 16'h3005;
    wb_if.dr = 3'd6;
    tick();
    wb_if.enable_writeback = 1'b0;
    wb_if.sr2 = 3'd6;
    #1;
    chk("pc_psr", {13'd0, wb_if.psr}, 16'h0001);
    chk("pc_vsr2", wb_if.vsr2, 16'h3005);
    chk("pc_cnt", wb_if.commit_count, 16'h0003);
    chk("b2b_pt", {15'd0, wb_if.enable_writeback_pt}, 16'h0001);

    // Illegal select.
    wb_if.enable_writeback = 1'b1;
    wb_if.W_Control = 2'd3;
    wb_if.aluout = 16'h1234;
    wb_if.dr  = 3'd2;
    wb_if.sr1 = 3'd2;
    tick();
    wb_if.enable_writeback = 1'b0;
    wb_if.W_Control = 2'd0;
    #1;
    chk("ill_r2", wb_if.vsr1, 16'h0000);
    chk("ill_psr", {13'd0, wb_if.psr}, 16'h0001);
    chk("ill_err", {15'd0, wb_if.wb_err}, 16'h0001);
    chk("ill_cnt", wb_if.commit_count, 16'h0003);
    chk("ill_pt", {15'd0, wb_if.enable_writeback_pt}, 16'h0000);
    tick();
    chk("ill_sticky", {15'd0, wb_if.wb_err}, 16'h0001);

    // Same-cycle read and write of R4.
    wb_if.enable_writeback = 1'b1;
    wb_if.aluout = 16'h0011;
    wb_if.dr = 3'd4;
    tick();
    wb_if.aluout = 16'h0022;
    wb_if.sr1 = 3'd4;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_vsr1", wb_if.vsr1, 16'h0022);
`else
    chk("byp_vsr1", wb_if.vsr1, 16'h0011);
`endif
    chk("byp_vsr2_other", wb_if.vsr2, 16'h3005);
    tick();
    wb_if.enable_writeback = 1'b0;
    #1;
    chk("byp_next", wb_if.vsr1, 16'h0022);
    chk("byp_cnt", wb_if.commit_count, 16'h0005);

    // Wrap: reset, then 65535 commits, then one more.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    wb_if.enable_writeback = 1'b1;
    wb_if.W_Control = 2'd0;
    wb_if.dr = 3'd7;
    for (int i = 0; i < 65535; i++) begin
      wb_if.aluout = i[15:0];
      tick();
    end
    chk("wrap_ffff", wb_if.commit_count, 16'hFFFF);
    tick();
    chk("wrap_zero", wb_if.commit_count, 16'h0000);

    // Reset asserted mid-commit.
    wb_if.aluout = 16'hABCD;
    wb_if.dr  = 3'd1;
    wb_if.sr1 = 3'd1;
    wb_if.sr2 = 3'd7;
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_vsr1", wb_if.vsr1, 16'h0000);
    chk("mrst_vsr2", wb_if.vsr2, 16'h0000);
    chk("mrst_psr", {13'd0, wb_if.psr}, 16'h0000);
    chk("mrst_cnt", wb_if.commit_count, 16'h0000);
    chk("mrst_pt", {15'd0, wb_if.enable_writeback_pt}, 16'h0000);
    chk("mrst_err", {15'd0, wb_if.wb_err}, 16'h0000);
    tick();
    wb_if.enable_writeback = 1'b0;
    reset = 1'b1;
    tick();
    chk("post_r1", wb_if.vsr1, 16'h0000);
    chk("post_cnt", wb_if.commit_count, 16'h0000);
    chk("post_pt", {15'd0, wb_if.enable_writeback_pt}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc3_writeback.md
# lc3_writeback

Writeback stage of the LC3 pipeline: selects the result from execute/memory (ALU, memory read data or PC), commits it to the 8x16 general-purpose register file and updates the 3-bit PSR condition codes. It also serves the register-file read ports back to execute as vsr1/vsr2, exactly the signal set sampled by the writeback_out agent, so it sits between execute/memaccess (upstream) and the writeback_out monitor/execute (downstream).

## Interface
Parameters:
- none (register count 8, data width 16 are architectural)

Ports:
- clock  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state while low
- enable_writeback  input  1  commit strobe from controller
- W_Control  input  2  result select: 0 aluout, 1 memout, 2 pcout, 3 illegal
- aluout  input  16  execute ALU result
- memout  input  16  memory read data
- pcout  input  16  execute PC-relative result (LEA)
- dr  input  3  destination register index
- sr1  input  3  read-port-1 index
- sr2  input  3  read-port-2 index
- vsr1  output  16  contents of R[sr1]
- vsr2  output  16  contents of R[sr2]
- psr  output  3  condition codes {N,Z,P}
- enable_writeback_pt  output  1  registered "write committed last cycle" flag
- wb_err  output  1  sticky: illegal W_Control seen while enabled
- commit_count  output  16  number of committed writes, wraps

## Operation
- DR_in = aluout / memout / pcout per W_Control 0/1/2.
- Commit when enable_writeback=1 and W_Control!=3: R[dr] <= DR_in; psr <= 3'b100 if DR_in[15]=1, 3'b010 if DR_in==0, else 3'b001; commit_count <= commit_count+1 (16-bit, 16'hFFFF wraps to 0); enable_writeback_pt <= 1.
- enable_writeback=1 and W_Control==3: no register/psr/count change; wb_err <= 1 (sticky until reset); enable_writeback_pt <= 0.
- enable_writeback=0: nothing changes; enable_writeback_pt <= 0.
- Read ports: vsr1 = R[sr1], vsr2 = R[sr2], combinational from stored contents (see Configuration for same-cycle write). sr1==sr2 allowed; both return same value.
- State: two-state commit FSM per cycle — IDLE (no commit) / COMMIT (enable_writeback_pt=1); IDLE->COMMIT on legal commit, COMMIT->IDLE when no legal commit in the current cycle; back-to-back commits hold COMMIT.

## Timing
- Reset (reset=0, asynchronous): R0..R7=16'h0000, psr=3'b000, enable_writeback_pt=0, wb_err=0, commit_count=0; hence vsr1=vsr2=16'h0000. Deassertion takes effect at next rising edge; no commit on the deassertion edge if reset still low at that edge.
- Reset asserted mid-commit: register file and all outputs clear immediately; partial write never visible.
- Write latency: R[dr], psr, commit_count visible one clock after the enabling edge (same cycle as enable_writeback_pt=1).
- Read latency: zero cycles (combinational) from sr1/sr2 or stored data.
- Simultaneous write and read of same register in one cycle: behaviour per WB_BYPASS_EN.
- Consecutive writes to same dr: last one wins; psr reflects the last committed value.

## Configuration
- WB_BYPASS_EN defined: write-through forwarding; when a legal commit is presented and sr1==dr (resp. sr2==dr), vsr1 (resp. vsr2) returns DR_in in that same cycle.
- WB_BYPASS_EN undefined: vsr1/vsr2 return the pre-write stored value until the edge; new value one cycle later (LC3 baseline, bench golden model default).

## Test plan
- Reset then idle: reset=0 for 3 cycles -> vsr1=vsr2=16'h0000, psr=000, commit_count=0, enable_writeback_pt=0.
- ALU commit: W_Control=0, aluout=16'h8001, dr=3, enable 1 cycle -> next cycle R3=16'h8001 (sr1=3 gives vsr1=16'h8001), psr=100, enable_writeback_pt=1 for one cycle, commit_count=1.
- Select/psr coverage: memout=16'h0000 (W_Control=1, dr=5) -> psr=010; pcout=16'h3005 (W_Control=2, dr=6) -> psr=001, R6=16'h3005.
- Illegal select: W_Control=3, enable=1, dr=2, aluout=16'h1234 -> R2 unchanged, psr unchanged, wb_err=1 and stays 1, commit_count unchanged.
- Same-cycle read/write: R4=16'h0011, commit 16'h0022 to dr=4 with sr1=4 -> vsr1=16'h0022 that cycle with WB_BYPASS_EN, 16'h0011 without; 16'h0022 next cycle either way.
- Wrap and async reset: 65536 commits -> commit_count=0; assert reset mid-commit -> all outputs zero immediately, no write after release.
